// File: rtl/friscv_inst_mem_responder.sv
// Instruction-memory responder for the fetch interface: returns the addressed word LATENCY
// cycles after each fetch, and exposes a preload write port for filling the program.
module friscv_inst_mem_responder #(
   parameter int unsigned ADDRW   = 16,
   parameter int unsigned XLEN    = 32,
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 1
) (
   input  logic             aclk,
   input  logic             arst,
   input  logic             inst_en,
   input  logic [ADDRW-1:0] inst_addr,
   output logic [XLEN-1:0]  inst_rdata,
   output logic             inst_ready,
   output logic             inst_err,
   input  logic             wr_en,
   input  logic [ADDRW-1:0] wr_addr,
   input  logic [XLEN-1:0]  wr_data,
   output logic [31:0]      req_cnt
);

   localparam int unsigned IDXW  = $clog2(DEPTH);
   localparam int unsigned WADRW = ADDRW - 2;
   localparam logic [XLEN-1:0] NOP_WORD = XLEN'(32'h0000_0013);

   logic [XLEN-1:0]  r_mem  [DEPTH];
   logic             r_vld  [LATENCY];
   logic [XLEN-1:0]  r_data [LATENCY];
   logic             r_err  [LATENCY];
   logic [31:0]      r_req_cnt;

   logic [WADRW-1:0] w_rd_word;
   logic [WADRW-1:0] w_wr_word;
   logic [IDXW-1:0]  w_rd_idx;
   logic [IDXW-1:0]  w_wr_idx;
   logic             w_rd_oor;
   logic             w_wr_oor;
   logic             w_misalign;
   logic             w_rd_err;
   logic [XLEN-1:0]  w_rd_data;
   logic             w_unused;

   // Word addressing; the range check uses the full word address before truncation.
   assign w_rd_word  = inst_addr[ADDRW-1:2];
   assign w_wr_word  = wr_addr[ADDRW-1:2];
   assign w_rd_oor   = 32'(w_rd_word) >= 32'(DEPTH);
   assign w_wr_oor   = 32'(w_wr_word) >= 32'(DEPTH);
   assign w_rd_idx   = w_rd_word[IDXW-1:0];
   assign w_wr_idx   = w_wr_word[IDXW-1:0];
   assign w_misalign = |inst_addr[1:0];
   assign w_rd_err   = w_misalign | w_rd_oor;
   assign w_unused   = ^wr_addr[1:0];

   always_comb begin
      w_rd_data = r_mem[w_rd_idx];
      if (w_rd_oor) begin
         w_rd_data = NOP_WORD;
      end
   end

   // Preload port; contents survive reset. Read-before-write falls out of the NBA.
   always_ff @(posedge aclk) begin
      if (wr_en && !w_wr_oor) begin
         r_mem[w_wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            r_vld[i]  <= 1'b0;
            r_data[i] <= '0;
            r_err[i]  <= 1'b0;
         end
         r_req_cnt <= 32'd0;
      end else begin
         r_vld[0]  <= inst_en;
         r_data[0] <= w_rd_data;
         r_err[0]  <= w_rd_err;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_data[i] <= r_data[i-1];
            r_err[i]  <= r_err[i-1];
         end
         if (inst_en) begin
            r_req_cnt <= r_req_cnt + 32'd1;
         end
      end
   end

   assign inst_ready = r_vld[LATENCY-1];
   assign inst_rdata = r_data[LATENCY-1];
   assign inst_err   = r_err[LATENCY-1];
   assign req_cnt    = r_req_cnt;

endmodule

// File: tb/tb_friscv_inst_mem_responder.sv
// Bench for friscv_inst_mem_responder: three instances (LATENCY 1, 3, 4) share one stimulus
// stream and are checked every cycle against a request-history model of the memory.
module tb_friscv_inst_mem_responder;

   localparam int DEPTH = 1024;
   localparam int HIST  = 1024;

   logic        aclk = 1'b0;
   logic        arst = 1'b1;
   logic        inst_en = 1'b0;
   logic [15:0] inst_addr = '0;
   logic        wr_en = 1'b0;
   logic [15:0] wr_addr = '0;
   logic [31:0] wr_data = '0;

   logic [31:0] rdata [3];
   logic        ready [3];
   logic        err   [3];
   logic [31:0] cnt   [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 aclk = ~aclk;

   friscv_inst_mem_responder #(.ADDRW(16), .XLEN(32), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
      .aclk(aclk), .arst(arst), .inst_en(inst_en), .inst_addr(inst_addr),
      .inst_rdata(rdata[0]), .inst_ready(ready[0]), .inst_err(err[0]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .req_cnt(cnt[0]));

   friscv_inst_mem_responder #(.ADDRW(16), .XLEN(32), .DEPTH(DEPTH), .LATENCY(3)) u_l3 (
      .aclk(aclk), .arst(arst), .inst_en(inst_en), .inst_addr(inst_addr),
      .inst_rdata(rdata[1]), .inst_ready(ready[1]), .inst_err(err[1]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .req_cnt(cnt[1]));

   friscv_inst_mem_responder #(.ADDRW(16), .XLEN(32), .DEPTH(DEPTH), .LATENCY(4)) u_l4 (
      .aclk(aclk), .arst(arst), .inst_en(inst_en), .inst_addr(inst_addr),
      .inst_rdata(rdata[2]), .inst_ready(ready[2]), .inst_err(err[2]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .req_cnt(cnt[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: every accepted edge is numbered; the response of edge e shows up after edge e+L-1.
   int unsigned  ecount   = 0;
   int unsigned  rst_mark = 0;
   int unsigned  cnt_m    = 0;
   logic         h_vld  [HIST];
   logic [31:0]  h_data [HIST];
   logic         h_err  [HIST];
   logic [31:0]  mem_m  [DEPTH];

   always @(posedge aclk or posedge arst) begin
      int a;
      int w;
      if (arst) begin
         rst_mark = ecount;
         cnt_m    = 0;
      end else begin
         ecount++;
         a = int'(inst_addr);
         h_vld[ecount % HIST] = inst_en;
         if (a >= DEPTH * 4) begin
            h_data[ecount % HIST] = 32'h0000_0013;
            h_err[ecount % HIST]  = 1'b1;
         end else begin
            h_data[ecount % HIST] = mem_m[a / 4];
            h_err[ecount % HIST]  = (a % 4) != 0;
         end
         w = int'(wr_addr);
         if (wr_en && w < DEPTH * 4) mem_m[w / 4] = wr_data;
         if (inst_en) cnt_m++;
      end
   end

   logic [32:0] got_l1 [$];

   // Per-cycle comparison of all three instances against the model.
   always @(negedge aclk) begin
      int lat;
      int idx;
      logic ev;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       lat = 1;
            1:       lat = 3;
            default: lat = 4;
         endcase
         idx = int'(ecount) - lat + 1;
         ev  = 1'b0;
         if (idx > int'(rst_mark)) ev = h_vld[idx % HIST];
         chk($sformatf("L%0d_ready", lat), 32'(ready[k]), 32'(ev));
         if (ev) begin
            chk($sformatf("L%0d_rdata", lat), rdata[k], h_data[idx % HIST]);
            chk($sformatf("L%0d_err", lat), 32'(err[k]), 32'(h_err[idx % HIST]));
         end
         chk($sformatf("L%0d_req_cnt", lat), cnt[k], cnt_m);
      end
      if (ready[0]) got_l1.push_back({err[0], rdata[0]});
   end

   task automatic drive(input logic en, input logic [15:0] a, input logic we,
                        input logic [15:0] wa, input logic [31:0] wd);
      inst_en   = en;
      inst_addr = a;
      wr_en     = we;
      wr_addr   = wa;
      wr_data   = wd;
   endtask

   function automatic logic [31:0] pre_word(input int i);
      logic [2:0] i3;
      i3 = 3'(i);
      return {17'b0, i3, 5'b0, 7'b0000011};
   endfunction

   initial begin
      int tot;
      int first;
      int after;
      int n4;

      drive(0, 0, 0, 0, 0);
      repeat (3) @(negedge aclk);
      chk("rst_ready", 32'(ready[0]), 32'd0);
      chk("rst_rdata", rdata[0], 32'd0);
      chk("rst_err", 32'(err[0]), 32'd0);
      chk("rst_req_cnt", cnt[0], 32'd0);
      chk("rst_rdata_l4", rdata[2], 32'd0);
      #1 arst = 1'b0;

      // Preload plus one out-of-range write that must not alias onto word 0.
      for (int i = 0; i < 16; i++) begin
         @(negedge aclk);
         drive(0, 0, 1, 16'(i * 4), pre_word(i));
      end
      @(negedge aclk);
      drive(0, 0, 1, 16'h1000, 32'hBAD0_0BAD);
      @(negedge aclk);
      drive(0, 0, 0, 0, 0);
      @(negedge aclk);
      got_l1.delete();

      for (int i = 0; i < 16; i++) begin
         drive(1, 16'(i * 4), 0, 0, 0);
         @(negedge aclk);
      end
      drive(0, 0, 0, 0, 0);
      repeat (6) @(negedge aclk);
      chk("burst16_count", 32'(got_l1.size()), 32'd16);
      for (int i = 0; i < 16 && i < got_l1.size(); i++) begin
         chk($sformatf("burst16_word%0d", i), got_l1[i][31:0], 32'h3 | (32'(i % 8) << 12));
         chk($sformatf("burst16_err%0d", i), 32'(got_l1[i][32]), 32'd0);
      end
      chk("burst16_req_cnt", cnt[0], 32'd16);

      // Eight-cycle burst observed on the LATENCY=3 instance.
      drive(1, 16'h0, 0, 0, 0);
      tot = 0; first = -1; after = 0;
      for (int j = 1; j <= 14; j++) begin
         @(negedge aclk);
         if (ready[1]) begin
            tot++;
            if (first < 0) first = j;
            if (j >= 8) after++;
         end
         if (j < 8) drive(1, 16'(4 * j), 0, 0, 0);
         else drive(0, 0, 0, 0, 0);
      end
      chk("l3_first_latency", 32'(first), 32'd3);
      chk("l3_total", 32'(tot), 32'd8);
      chk("l3_after_drop", 32'(after), 32'd3);
      chk("l3_req_cnt", cnt[1], 32'd24);

      // Misaligned and out-of-range fetches.
      drive(1, 16'h0006, 0, 0, 0);
      @(negedge aclk);
      drive(0, 0, 0, 0, 0);
      chk("misalign_ready", 32'(ready[0]), 32'd1);
      chk("misalign_data", rdata[0], 32'h0000_1003);
      chk("misalign_err", 32'(err[0]), 32'd1);
      drive(1, 16'h1000, 0, 0, 0);
      @(negedge aclk);
      chk("oor_data", rdata[0], 32'h0000_0013);
      chk("oor_err", 32'(err[0]), 32'd1);
      drive(1, 16'hFFFC, 0, 0, 0);
      @(negedge aclk);
      drive(0, 0, 0, 0, 0);
      chk("oor_top_data", rdata[0], 32'h0000_0013);

      // Same-cycle write and fetch of one word.
      drive(1, 16'h0010, 1, 16'h0010, 32'hDEAD_BEEF);
      @(negedge aclk);
      drive(0, 0, 0, 0, 0);
      chk("collide_old", rdata[0], 32'h0000_4003);
      drive(1, 16'h0010, 0, 0, 0);
      @(negedge aclk);
      chk("collide_new", rdata[0], 32'hDEAD_BEEF);
      drive(1, 16'h0000, 0, 0, 0);
      @(negedge aclk);
      drive(0, 0, 0, 0, 0);
      chk("oor_write_ignored", rdata[0], 32'h0000_0003);

      // Reset with three requests in flight on the LATENCY=4 instance.
      repeat (5) @(negedge aclk);
      for (int k = 0; k < 3; k++) begin
         drive(1, 16'(8 + 4 * k), 0, 0, 0);
         @(negedge aclk);
      end
      drive(0, 0, 0, 0, 0);
      #1 arst = 1'b1;
      repeat (2) @(negedge aclk);
      #1 arst = 1'b0;
      n4 = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge aclk);
         if (ready[2]) n4++;
      end
      chk("rst_flight_l4_pulses", 32'(n4), 32'd0);
      chk("rst_flight_req_cnt", cnt[2], 32'd0);
      drive(1, 16'h0008, 0, 0, 0);
      @(negedge aclk);
      chk("mem_kept_word2", rdata[0], 32'h0000_2003);
      chk("post_rst_req_cnt", cnt[0], 32'd1);
      drive(1, 16'h0010, 0, 0, 0);
      @(negedge aclk);
      drive(0, 0, 0, 0, 0);
      chk("mem_kept_word4", rdata[0], 32'hDEAD_BEEF);
      repeat (6) @(negedge aclk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/friscv_inst_mem_responder.md
# friscv_inst_mem_responder

Instruction-memory responder for the fetch interface of `friscv_rv32i_control`. It answers every fetch (`inst_en`/`inst_addr`) with the addressed 32-bit word on `inst_rdata`, qualified by a one-cycle `inst_ready` pulse exactly LATENCY cycles later. It also carries a preload write port so benches and the SoC loader can fill the program before release. It is the memory-side end of the fetch protocol and is used both in unit benches and as the default on-chip instruction RAM.

## Interface
- ADDRW, 16: byte-address width of `inst_addr` and `wr_addr`.
- XLEN, 32: data width; only 32 is supported.
- DEPTH, 1024: memory size in 32-bit words; power of two, DEPTH*4 <= 2**ADDRW.
- LATENCY, 1: request-to-response delay in cycles; legal range 1..4.
- aclk  in  1  clock; all logic on its rising edge.
- arst  in  1  reset, asynchronous and active-high.
- inst_en  in  1  fetch request; one request accepted per cycle while high.
- inst_addr  in  ADDRW  byte address of the fetch.
- inst_rdata  out  XLEN  returned instruction word.
- inst_ready  out  1  response valid, one cycle per accepted request.
- inst_err  out  1  qualifies the current response as misaligned or out of range; valid only with `inst_ready`.
- wr_en  in  1  preload write strobe.
- wr_addr  in  ADDRW  byte address of the preload word.
- wr_data  in  XLEN  preload word.
- req_cnt  out  32  number of accepted fetches since reset; wraps modulo 2**32.

## Operation
- Word index is `inst_addr[ADDRW-1:2]` truncated to log2(DEPTH) bits after the range check.
- Request acceptance: every cycle with `inst_en`=1 is accepted. There is no backpressure toward the requester.
- Response pipeline: a LATENCY-stage shift register holding {valid, data, err}.
  - Stage 0 loads on every rising edge: valid=`inst_en`, data=mem[index], err=flag.
  - Each later stage copies the previous one.
  - `inst_ready`, `inst_rdata` and `inst_err` are driven from the last stage.
- Misaligned request (`inst_addr[1:0]` != 0):
  - The response still occurs.
  - Data is the aligned word, with the address bits [1:0] ignored.
  - `inst_err`=1.
- Out-of-range request (`inst_addr` >= DEPTH*4): data = 32'h0000_0013 (NOP) and `inst_err`=1.
- Preload write: with `wr_en`=1, mem[`wr_addr[ADDRW-1:2]`] <= `wr_data`.
  - Out-of-range writes are ignored.
  - `wr_addr[1:0]` is ignored.
- Read/write collision on the same word in the same cycle is read-before-write: the response carries the old data, and the next fetch sees the new data.
- `req_cnt` increments by 1 on each accepted request.
- Memory contents are not affected by reset.

## Timing
- Reset values while `arst`=1:
  - `inst_ready`=0, `inst_rdata`=0, `inst_err`=0, `req_cnt`=0.
  - All pipeline valid bits are 0 and all pipeline data is 0.
- Latency: a request sampled at edge N produces `inst_ready`=1 during the cycle after edge N+LATENCY-1. For LATENCY=1 the data is visible right after the sampling edge.
- Throughput is one response per cycle. Back-to-back requests give back-to-back responses in request order, with no bubbles.
- After `inst_en` falls, exactly the in-flight requests (at most LATENCY) still complete. The requester must absorb them; `friscv_rv32i_control` stores the extra word.
- When `inst_ready`=0, `inst_rdata` holds the value last shifted through the pipeline. Nothing may depend on it.
- Reset mid-operation drops all in-flight responses. No `inst_ready` appears after `arst` deasserts unless a new request is made.
- Deassertion of `arst` is synchronized by the SoC. The first request is accepted on the first edge with `arst`=0.
- Counter wrap: 32'hFFFF_FFFF + 1 -> 0, with no flag.

## Test plan
- Preload mem[0..15] = {17'b0, i[2:0], 5'b0, 7'b0000011}, then issue 16 back-to-back fetches at 0x0..0x3C with LATENCY=1 -> 16 consecutive `inst_ready` pulses with matching words in order, `inst_err`=0, `req_cnt`=16.
- LATENCY=3: hold `inst_en` for 8 cycles, then drop it -> exactly 3 responses arrive after the drop, the total is 8, and the first response appears 3 cycles after the first request edge.
- Fetch 0x6 -> data = word at 0x4, `inst_err`=1. Fetch DEPTH*4 -> data = 32'h0000_0013, `inst_err`=1.
- Same-cycle `wr_en` to 0x10 with 32'hDEAD_BEEF and fetch of 0x10 -> response returns the old word. The next fetch of 0x10 returns 32'hDEAD_BEEF.
- Assert `arst` with 3 requests in flight (LATENCY=4), then release -> no `inst_ready` is seen, `req_cnt`=0, and memory still holds the preloaded words.
- Drive `friscv_rv32i_control` against the responder with the ALU stalled -> the control FIFO fills, one extra word is stored, and after `alu_ready`=1 all instructions reach `alu_instbus` in order.
